pc_ras: RTL and testbench

//  Parametrised program counter with a hardware return-address stack (RAS).

---
 rtl/pc_ras_if.sv | 42 ++++
 rtl/pc_ras.sv | 110 +++++++++++
 tb/tb_pc_ras.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_ras_if.sv
// PC / return-address-stack control bus between the control unit (master) and pc_ras (slave).
// Optional exception signals exist only when PC_EXC_EN is defined.
interface pc_ras_if #(
  parameter int AW        = 16,
  parameter int RAS_DEPTH = 4,
  localparam int CW       = $clog2(RAS_DEPTH + 1)
);
  logic          enable;
  logic          load;
  logic          call;
  logic          ret;
  logic [AW-1:0] in;
  logic [AW-1:0] address;
  logic [CW-1:0] ras_count;
  logic          ras_full;
  logic          ras_empty;
  logic          ras_ovf;
  logic          ras_unf;
`ifdef PC_EXC_EN
  logic          exc;
  logic          eret;
  logic [AW-1:0] epc;
`endif

  modport master (
    output enable, load, call, ret, in,
`ifdef PC_EXC_EN
    output exc, eret,
    input  epc,
`endif
    input  address, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
  );

  modport slave (
    input  enable, load, call, ret, in,
`ifdef PC_EXC_EN
    input  exc, eret,
    output epc,
`endif
    output address, ras_count, ras_full, ras_empty, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_ras.sv
// Program counter with circular return-address stack and sticky overflow/underflow flags.
// Define PC_EXC_EN to add exception entry (exc) and return (eret) with a saved epc.
module pc_ras #(
  parameter int          AW         = 16,
  parameter int          STEP       = 2,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  parameter int          RAS_DEPTH  = 4,
  parameter logic [AW-1:0] EXC_VECTOR = 16'h10,
  localparam int         CW         = $clog2(RAS_DEPTH + 1),
  localparam int         PW         = $clog2(RAS_DEPTH)
) (
  input logic    clk,
  input logic    rst,
  pc_ras_if.slave bus
);
  logic [AW-1:0] stack [RAS_DEPTH];
  logic [AW-1:0] addr_q, addr_n, seq, top;
  logic [PW-1:0] ptr_q, ptr_n, ptr_inc, ptr_dec;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          full_q, empty_q, ovf_q, ovf_n, unf_q, unf_n, push;
`ifdef PC_EXC_EN
  logic [AW-1:0] epc_q, epc_n;
`endif

  assign seq = addr_q + AW'(STEP);
  // ptr_q is the next write slot; when full it also points at the oldest entry,
  // so a push while full overwrites it naturally.
  assign ptr_inc = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - 1'b1;
  assign top     = stack[ptr_dec];

  always_comb begin
    addr_n = addr_q;
    ptr_n  = ptr_q;
    cnt_n  = cnt_q;
    ovf_n  = ovf_q;
    unf_n  = unf_q;
    push   = 1'b0;
`ifdef PC_EXC_EN
    epc_n  = epc_q;
    if (bus.exc) begin
      epc_n  = addr_q;
      addr_n = EXC_VECTOR;
    end else if (bus.enable && bus.eret)
      addr_n = epc_q;
    else
`endif
    if (bus.enable) begin
      if (bus.ret) begin
        if (cnt_q != '0) begin
          addr_n = top;
          ptr_n  = ptr_dec;
          cnt_n  = cnt_q - 1'b1;
        end else begin
          addr_n = seq;
          unf_n  = 1'b1;
        end
      end else if (bus.call) begin
        push   = 1'b1;
        addr_n = bus.in;
        ptr_n  = ptr_inc;
        if (full_q) ovf_n = 1'b1;
        else        cnt_n = cnt_q + 1'b1;
      end else if (bus.load)
        addr_n = bus.in;
      else
        addr_n = seq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= RESET_ADDR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      full_q  <= (cnt_n == CW'(RAS_DEPTH));
      empty_q <= (cnt_n == '0);
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (!rst && push) stack[ptr_q] <= seq;
  end

`ifdef PC_EXC_EN
  always_ff @(posedge clk) begin
    if (rst) epc_q <= '0;
    else     epc_q <= epc_n;
  end
  assign bus.epc = epc_q;
`endif

  assign bus.address   = addr_q;
  assign bus.ras_count = cnt_q;
  assign bus.ras_full  = full_q;
  assign bus.ras_empty = empty_q;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras (AW=16, STEP=2, RESET_ADDR=0, RAS_DEPTH=4).
module tb_pc_ras;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_ras_if #(.AW(16), .RAS_DEPTH(4)) bus ();

  pc_ras #(.AW(16), .STEP(2), .RESET_ADDR(16'h0), .RAS_DEPTH(4), .EXC_VECTOR(16'h10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic ld, input logic cl, input logic rt,
                     input logic [15:0] tgt);
    bus.enable = en; bus.load = ld; bus.call = cl; bus.ret = rt; bus.in = tgt;
    @(posedge clk); #1;
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] cnt, input logic full,
                           input logic empty, input logic ovf, input logic unf);
    chk({tag, "_cnt"},   32'(bus.ras_count), 32'(cnt));
    chk({tag, "_full"},  32'(bus.ras_full),  32'(full));
    chk({tag, "_empty"}, 32'(bus.ras_empty), 32'(empty));
    chk({tag, "_ovf"},   32'(bus.ras_ovf),   32'(ovf));
    chk({tag, "_unf"},   32'(bus.ras_unf),   32'(unf));
  endtask

  initial begin
    bus.enable = 0; bus.load = 0; bus.call = 0; bus.ret = 0; bus.in = '0;
`ifdef PC_EXC_EN
    bus.exc = 0; bus.eret = 0;
`endif
    // 1 reset
    rst = 1; cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    rst = 0; cyc(0, 0, 0, 0, 0);
    chk("rst_addr", 32'(bus.address), 32'h0);
    chk_flags("rst", 0, 0, 1, 0, 0);

    // 2 increment and hold
    cyc(1, 0, 0, 0, 0); chk("inc1", 32'(bus.address), 32'h2);
    cyc(1, 0, 0, 0, 0); chk("inc2", 32'(bus.address), 32'h4);
    cyc(1, 0, 0, 0, 0); chk("inc3", 32'(bus.address), 32'h6);
    cyc(0, 1, 0, 0, 16'h8900); chk("hold", 32'(bus.address), 32'h6);
    cyc(0, 0, 1, 1, 16'h8900); chk("hold_cr", 32'(bus.address), 32'h6);
    chk_flags("hold", 0, 0, 1, 0, 0);

    // 3 load and wrap
    cyc(1, 1, 0, 0, 16'h6555); chk("load", 32'(bus.address), 32'h6555);
    cyc(1, 0, 0, 0, 0);        chk("load_inc", 32'(bus.address), 32'h6557);
    cyc(1, 1, 0, 0, 16'hFFFE); chk("load_fffe", 32'(bus.address), 32'hFFFE);
    cyc(1, 0, 0, 0, 0);        chk("wrap", 32'(bus.address), 32'h0);

    // 4 single call/return
    cyc(1, 1, 0, 0, 16'h0040);
    cyc(1, 1, 1, 0, 16'h0100); chk("call1", 32'(bus.address), 32'h0100);
    chk_flags("call1", 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);        chk("ret1", 32'(bus.address), 32'h0042);
    chk_flags("ret1", 0, 0, 1, 0, 0);

    // 5 overflow: pushes 0x44,0x102,0x202,0x302 then 0x402 overwrites 0x44
    cyc(1, 0, 1, 0, 16'h0100);
    cyc(1, 0, 1, 0, 16'h0200);
    cyc(1, 0, 1, 0, 16'h0300);
    cyc(1, 0, 1, 0, 16'h0400);
    chk_flags("four", 4, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 16'h0500); chk("call5", 32'(bus.address), 32'h0500);
    chk_flags("ovf", 4, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 16'h1234); chk("pop1", 32'(bus.address), 32'h0402);
    cyc(1, 0, 0, 1, 0);        chk("pop2", 32'(bus.address), 32'h0302);
    cyc(1, 0, 0, 1, 0);        chk("pop3", 32'(bus.address), 32'h0202);
    cyc(1, 0, 0, 1, 0);        chk("pop4", 32'(bus.address), 32'h0102);
    chk_flags("pop4", 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0);        chk("unf_addr", 32'(bus.address), 32'h0104);
    chk_flags("unf", 0, 0, 1, 1, 1);
    cyc(1, 0, 0, 0, 0);        chk_flags("sticky", 0, 0, 1, 1, 1);

    // 6 call+ret same cycle, then reset mid call burst
    cyc(1, 0, 1, 0, 16'h0600); chk("c6", 32'(bus.address), 32'h0600);
    cyc(1, 0, 1, 1, 16'h0900); chk("callret", 32'(bus.address), 32'h0108);
    chk("callret_cnt", 32'(bus.ras_count), 32'h0);
    cyc(1, 0, 1, 0, 16'h0700);
    cyc(1, 0, 1, 0, 16'h0800); chk("burst_cnt", 32'(bus.ras_count), 32'h2);
    rst = 1; cyc(1, 0, 1, 0, 16'h0A00);
    chk("midrst_addr", 32'(bus.address), 32'h0);
    chk_flags("midrst", 0, 0, 1, 0, 0);
    rst = 0;
    cyc(1, 0, 0, 1, 0);        chk("postrst_ret", 32'(bus.address), 32'h2);

`ifdef PC_EXC_EN
    chk("epc_rst", 32'(bus.epc), 32'h0);
    cyc(1, 1, 0, 0, 16'h0020);
    bus.exc = 1; cyc(0, 0, 0, 0, 0); bus.exc = 0;
    chk("exc_addr", 32'(bus.address), 32'h0010);
    chk("exc_epc",  32'(bus.epc), 32'h0020);
    bus.eret = 1; cyc(1, 0, 0, 1, 0); bus.eret = 0;
    chk("eret", 32'(bus.address), 32'h0020);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
